// File: rtl/adder_subtractor_24bit_if.sv
// Operand/result bundle for the 24-bit mantissa adder/subtractor.
// The master drives the operands and op select; the slave returns the registered result.
interface adder_subtractor_24bit_if;
  logic [23:0] reg1;
  logic [23:0] reg2;
  logic        op;
  logic [23:0] result;
  logic        cout;

  modport master (
    output reg1,
    output reg2,
    output op,
    input  result,
    input  cout
  );

  modport slave (
    input  reg1,
    input  reg2,
    input  op,
    output result,
    output cout
  );
endinterface

// File: rtl/adder_subtractor_24bit.sv
// Registered 24-bit unsigned adder/subtractor: six 4-bit carry-lookahead groups of
// full-adder cells, B conditioned by XOR with op, carry-in = op, one-cycle latency.

module adder_subtractor_24bit_fa (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic p_o,
  output logic g_o
);
  // Cell exposes propagate/generate so the group can compute its carries in parallel.
  assign p_o = a_i ^ b_i;
  assign g_o = a_i & b_i;
  assign s_o = p_o ^ c_i;
endmodule

module adder_subtractor_24bit_cla4 (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       cin_i,
  output logic [3:0] s_o,
  output logic       cout_o
);
  logic [3:0] p;
  logic [3:0] g;
  logic [4:0] c;

  assign c[0] = cin_i;
  assign c[1] = g[0] | (p[0] & cin_i);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin_i);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin_i);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin_i);
  assign cout_o = c[4];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_cell
      adder_subtractor_24bit_fa u_fa (
        .a_i (a_i[gi]),
        .b_i (b_i[gi]),
        .c_i (c[gi]),
        .s_o (s_o[gi]),
        .p_o (p[gi]),
        .g_o (g[gi])
      );
    end
  endgenerate
endmodule

module adder_subtractor_24bit (
  input  logic                     clk,
  input  logic                     rst,
  adder_subtractor_24bit_if.slave  bus
);
  localparam int NGROUPS = 6;

  logic [23:0]      b_cond;
  logic [NGROUPS:0] grp_c;
  logic [23:0]      result_d;
  logic             cout_d;
  logic [23:0]      result_q;
  logic             cout_q;

  // Subtraction is A + ~B + 1, so op doubles as the inversion mask and the carry-in.
  assign b_cond   = bus.reg2 ^ {24{bus.op}};
  assign grp_c[0] = bus.op;

  genvar gi;
  generate
    for (gi = 0; gi < NGROUPS; gi++) begin : g_grp
      adder_subtractor_24bit_cla4 u_cla (
        .a_i    (bus.reg1[gi*4 +: 4]),
        .b_i    (b_cond[gi*4 +: 4]),
        .cin_i  (grp_c[gi]),
        .s_o    (result_d[gi*4 +: 4]),
        .cout_o (grp_c[gi+1])
      );
    end
  endgenerate

  assign cout_d = grp_c[NGROUPS];

  // Constant reset values keep unknown operands out of the outputs while rst is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= 24'h000000;
      cout_q   <= 1'b0;
    end else begin
      result_q <= result_d;
      cout_q   <= cout_d;
    end
  end

  assign bus.result = result_q;
  assign bus.cout   = cout_q;
endmodule

// File: tb/tb_adder_subtractor_24bit.sv
// Directed and random checks of the registered 24-bit adder/subtractor.
module tb_adder_subtractor_24bit;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  adder_subtractor_24bit_if bus ();

  adder_subtractor_24bit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1ns after a rising edge; outputs are sampled at the same point.
  task automatic drive(input logic [23:0] a, input logic [23:0] b, input logic o);
    bus.reg1 = a;
    bus.reg2 = b;
    bus.op   = o;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(24'd30, 24'd10, 1'b0);
    for (int i = 0; i < 2; i++) begin
      tick();
      n_cmp++;
      if ({bus.cout, bus.result} !== {1'b0, 24'h000000}) begin
        n_err++;
        $display("FAIL reset_hold%0d: got cout=%b result=%h, want cout=0 result=000000",
                 i, bus.cout, bus.result);
      end
    end
    rst = 1'b0;
    tick();
    n_cmp++;
    if ({bus.cout, bus.result} !== {1'b0, 24'd40}) begin
      n_err++;
      $display("FAIL reset_release: got cout=%b result=%h, want cout=0 result=000028",
               bus.cout, bus.result);
    end
  endtask

  task automatic test_back_to_back();
    logic [23:0] va  [6] = '{24'd30, 24'd10, 24'd5, 24'd30, 24'd5, 24'd30};
    logic [23:0] vb  [6] = '{24'd10, 24'd20, 24'd10, 24'd10, 24'd10, 24'd10};
    logic        vo  [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [23:0] er  [6] = '{24'd40, 24'd30, 24'hFFFFFB, 24'd40, 24'hFFFFFB, 24'd20};
    logic        ec  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 6; i++) begin
      drive(va[i], vb[i], vo[i]);
      tick();
      n_cmp++;
      if ({bus.cout, bus.result} !== {ec[i], er[i]}) begin
        n_err++;
        $display("FAIL b2b%0d: got cout=%b result=%h, want cout=%b result=%h",
                 i, bus.cout, bus.result, ec[i], er[i]);
      end
    end
  endtask

  task automatic test_add_wrap();
    logic [23:0] va [3] = '{24'hFFFFFF, 24'h800000, 24'h000000};
    logic [23:0] vb [3] = '{24'h000001, 24'h800000, 24'h000000};
    logic [23:0] er [3] = '{24'h000000, 24'h000000, 24'h000000};
    logic        ec [3] = '{1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      drive(va[i], vb[i], 1'b0);
      tick();
      n_cmp++;
      if ({bus.cout, bus.result} !== {ec[i], er[i]}) begin
        n_err++;
        $display("FAIL add_wrap%0d: got cout=%b result=%h, want cout=%b result=%h",
                 i, bus.cout, bus.result, ec[i], er[i]);
      end
    end
  endtask

  task automatic test_sub_edges();
    logic [23:0] va [3] = '{24'd10, 24'd0, 24'hFFFFFF};
    logic [23:0] vb [3] = '{24'd10, 24'd1, 24'd0};
    logic [23:0] er [3] = '{24'h000000, 24'hFFFFFF, 24'hFFFFFF};
    logic        ec [3] = '{1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      drive(va[i], vb[i], 1'b1);
      tick();
      n_cmp++;
      if ({bus.cout, bus.result} !== {ec[i], er[i]}) begin
        n_err++;
        $display("FAIL sub_edge%0d: got cout=%b result=%h, want cout=%b result=%h",
                 i, bus.cout, bus.result, ec[i], er[i]);
      end
    end
  endtask

  task automatic test_reset_midstream();
    drive(24'd100, 24'd1, 1'b0);
    tick();
    n_cmp++;
    if ({bus.cout, bus.result} !== {1'b0, 24'd101}) begin
      n_err++;
      $display("FAIL mid_pre: got cout=%b result=%h, want cout=0 result=000065",
               bus.cout, bus.result);
    end
    rst = 1'b1;
    drive(24'hFFFFFF, 24'hFFFFFF, 1'b0);
    tick();
    n_cmp++;
    if ({bus.cout, bus.result} !== {1'b0, 24'h000000}) begin
      n_err++;
      $display("FAIL mid_rst: got cout=%b result=%h, want cout=0 result=000000",
               bus.cout, bus.result);
    end
    rst = 1'b0;
    drive(24'd7, 24'd3, 1'b1);
    tick();
    n_cmp++;
    if ({bus.cout, bus.result} !== {1'b1, 24'd4}) begin
      n_err++;
      $display("FAIL mid_resume: got cout=%b result=%h, want cout=1 result=000004",
               bus.cout, bus.result);
    end
  endtask

  task automatic test_random();
    logic [23:0] a;
    logic [23:0] b;
    logic        o;
    logic [24:0] exp;
    for (int i = 0; i < 10000; i++) begin
      a = 24'($urandom);
      b = 24'($urandom);
      o = 1'($urandom_range(0, 1));
      if (o) exp = {(a >= b), 24'(a - b)};
      else   exp = {1'b0, a} + {1'b0, b};
      drive(a, b, o);
      tick();
      n_cmp++;
      if ({bus.cout, bus.result} !== exp) begin
        n_err++;
        $display("FAIL random%0d: a=%h b=%h op=%b got cout=%b result=%h, want cout=%b result=%h",
                 i, a, b, o, bus.cout, bus.result, exp[24], exp[23:0]);
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b1;
    drive(24'd0, 24'd0, 1'b0);
    #1;
    test_reset();
    test_back_to_back();
    test_add_wrap();
    test_sub_edges();
    test_reset_midstream();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
